// File: rtl/fpa_pkg.sv
// Shared types and IEEE-754 single-precision field constants for the fpa datapath.
package fpa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam int FP_W    = 32;
  localparam int FP_SIGN = 31;
  localparam int EXP_HI  = 30;
  localparam int EXP_LO  = 23;
  localparam int MAN_HI  = 22;
  localparam int MAN_LO  = 0;

  // Denormals use an effective exponent of 1.
  function automatic logic [7:0] fp_exp(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

  // Significand with the hidden bit restored (0 for denormals).
  function automatic logic [23:0] fp_sig(input logic [7:0] e, input logic [22:0] f);
    return {(e != 8'd0), f};
  endfunction

endpackage

// File: rtl/fpa.sv
// Combinational single-precision adder, round-to-nearest-even.
module fpa
  import fpa_pkg::*;
(
  input  logic [FP_W-1:0] op_a,
  input  logic [FP_W-1:0] op_b,
  output logic [FP_W-1:0] sum
);

  logic        sa, sb, sl;
  logic [7:0]  ea, eb, el, es, d;
  logic [23:0] ml, ms;
  logic        a_inf, b_inf, a_nan, b_nan, swap;
  logic        lost, rup, found;
  logic [26:0] xs;
  logic [27:0] acc;
  logic [9:0]  e, lz;
  logic [24:0] rnd;

  assign sa    = op_a[FP_SIGN];
  assign sb    = op_b[FP_SIGN];
  assign ea    = op_a[EXP_HI:EXP_LO];
  assign eb    = op_b[EXP_HI:EXP_LO];
  assign a_inf = (ea == 8'hFF) && (op_a[MAN_HI:MAN_LO] == '0);
  assign b_inf = (eb == 8'hFF) && (op_b[MAN_HI:MAN_LO] == '0);
  assign a_nan = (ea == 8'hFF) && (op_a[MAN_HI:MAN_LO] != '0);
  assign b_nan = (eb == 8'hFF) && (op_b[MAN_HI:MAN_LO] != '0);
  assign swap  = op_b[FP_SIGN-1:0] > op_a[FP_SIGN-1:0];

  // Order operands by magnitude so the effective subtraction never goes negative.
  always_comb begin
    if (swap) begin
      sl = sb;
      el = fp_exp(eb);
      ml = fp_sig(eb, op_b[MAN_HI:MAN_LO]);
      es = fp_exp(ea);
      ms = fp_sig(ea, op_a[MAN_HI:MAN_LO]);
    end else begin
      sl = sa;
      el = fp_exp(ea);
      ml = fp_sig(ea, op_a[MAN_HI:MAN_LO]);
      es = fp_exp(eb);
      ms = fp_sig(eb, op_b[MAN_HI:MAN_LO]);
    end
  end

  // Align, add/subtract, normalise (bounded by the denormal floor), round, pack.
  always_comb begin
    d     = el - es;
    lost  = 1'b0;
    found = 1'b0;
    lz    = '0;
    if (d > 8'd26) begin
      xs = {26'd0, |ms};
    end else begin
      lost = (({ms, 3'b000} << (8'd27 - d)) != 27'd0);
      xs   = ({ms, 3'b000} >> d) | {26'd0, lost};
    end
    acc = (sa ^ sb) ? ({1'b0, ml, 3'b000} - {1'b0, xs})
                    : ({1'b0, ml, 3'b000} + {1'b0, xs});
    e = {2'b00, el};
    if (acc[27]) begin
      acc = {1'b0, acc[27:2], acc[1] | acc[0]};
      e   = e + 10'd1;
    end else begin
      for (int unsigned i = 0; i < 27; i++) begin
        if (!found) begin
          if (acc[26 - i]) found = 1'b1;
          else             lz    = lz + 10'd1;
        end
      end
      if (lz > e - 10'd1) lz = e - 10'd1;
      acc = acc << lz;
      e   = e - lz;
    end
    rup = acc[2] & (acc[3] | acc[1] | acc[0]);
    rnd = {1'b0, acc[26:3]} + {24'd0, rup};
    if (rnd[24]) begin
      rnd = {1'b0, rnd[24:1]};
      e   = e + 10'd1;
    end
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) sum = {1'b0, 8'hFF, 1'b1, 22'd0};
    else if (a_inf)          sum = {sa, 8'hFF, 23'd0};
    else if (b_inf)          sum = {sb, 8'hFF, 23'd0};
    else if (rnd == '0)      sum = {sa & sb, 31'd0};
    else if (e >= 10'd255)   sum = {sl, 8'hFF, 23'd0};
    else                     sum = {sl, rnd[23] ? e[7:0] : 8'd0, rnd[22:0]};
  end

endmodule

// File: rtl/fpa_arbiter.sv
// Round-robin front end sharing one combinational fpa between two requesters,
// with a multicycle settle window and a held, handshaken response.
module fpa_arbiter
  import fpa_pkg::*;
#(
  parameter int unsigned LAT = 2,
  parameter int unsigned W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_c,
  output logic         resp_id,
  output logic         busy
);

  state_t       state;
  logic         ptr, id, gnt, acc;
  logic [3:0]   cnt;
  logic [W-1:0] op_a, op_b, sum, sel_a, sel_b;

  // Grant the lone requester, or ptr under contention; ready only in IDLE out of reset.
  always_comb begin
    gnt        = (req0_valid && req1_valid) ? ptr : req1_valid;
    req0_ready = !rst && (state == IDLE) && !gnt && req0_valid;
    req1_ready = !rst && (state == IDLE) &&  gnt && req1_valid;
  end

  // Operand mux for the winner; subtraction flips the sign of b.
  always_comb begin
    if (gnt) begin
      sel_a = req1_a;
      sel_b = req1_sub ? {~req1_b[W-1], req1_b[W-2:0]} : req1_b;
    end else begin
      sel_a = req0_a;
      sel_b = req0_sub ? {~req0_b[W-1], req0_b[W-2:0]} : req0_b;
    end
  end

  assign acc  = req0_ready || req1_ready;
  assign busy = (state != IDLE);

  fpa u_fpa (
    .op_a (op_a),
    .op_b (op_b),
    .sum  (sum)
  );

  // Control FSM with registered operands and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      id         <= 1'b0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_c     <= '0;
      resp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            id    <= gnt;
            ptr   <= ~gnt;
            cnt   <= 4'(LAT - 1);
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            resp_c     <= sum;
            resp_id    <= id;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpa_arbiter.sv
// Self-checking bench for fpa_arbiter: directed scenarios plus randomized
// transactions checked against a fixed-point arithmetic reference.
module tb_fpa_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [31:0] resp_c;

  int checks = 0;
  int errors = 0;
  bit last   = 1'b1;   // requester served most recently; the other one wins a tie

  fpa_arbiter #(.LAT(LAT), .W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_c     (resp_c),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Float bits -> signed value in units of 1/16 (exact for the operands used here).
  function automatic longint to_fix(input logic [31:0] x);
    longint m;
    int     sh;
    if (x[30:23] == 8'd0) return 0;
    m  = longint'({1'b1, x[22:0]});
    sh = int'(x[30:23]) - 146;
    m  = (sh >= 0) ? (m << sh) : (m >> (-sh));
    return x[31] ? -m : m;
  endfunction

  // Signed value in units of 1/16 -> float bits.
  function automatic logic [31:0] from_fix(input longint s);
    longint      mag;
    int          p;
    logic [31:0] r;
    if (s == 0) return 32'h0;
    mag = (s < 0) ? -s : s;
    p   = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) p = i;
    r[31]    = (s < 0);
    r[30:23] = 8'(p + 123);
    r[22:0]  = 23'(mag << (23 - p));
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    longint v;
    v = longint'($urandom_range(255, 1)) << $urandom_range(8, 0);
    if ($urandom_range(1, 0) == 1) v = -v;
    return from_fix(v);
  endfunction

  // Reference: infinities by IEEE rules, finite values by exact arithmetic.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input bit sub);
    bit a_inf, b_inf, sbe;
    a_inf = (a[30:23] == 8'hFF);
    b_inf = (b[30:23] == 8'hFF);
    sbe   = b[31] ^ sub;
    if (a_inf && b_inf) return (a[31] == sbe) ? a : 32'h7FC00000;
    if (a_inf) return a;
    if (b_inf) return {sbe, 8'hFF, 23'd0};
    return sub ? from_fix(to_fix(a) - to_fix(b)) : from_fix(to_fix(a) + to_fix(b));
  endfunction

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_sub = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_c", resp_c, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    last = 1'b1;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_resp_valid", resp_valid, 0);
  endtask

  // One transaction from IDLE: present, accept, settle, optional backpressure, handshake.
  task automatic txn(input bit v0, input bit v1,
                     input logic [31:0] a0, input logic [31:0] b0, input bit s0,
                     input logic [31:0] a1, input logic [31:0] b1, input bit s1,
                     input int unsigned bp, input bit pulse1,
                     output logic [31:0] got_c, output logic got_id);
    bit          g;
    logic [31:0] exp_c;
    g     = (v0 && v1) ? ~last : v1;
    exp_c = g ? ref_add(a1, b1, s1) : ref_add(a0, b0, s0);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    resp_ready = (bp == 0);
    #1;
    chk("idle_busy", busy, 0);
    chk("grant_ready0", req0_ready, !g);
    chk("grant_ready1", req1_ready, g);
    @(posedge clk);
    #1;
    last = g;
    if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
    for (int unsigned k = 1; k <= LAT; k++) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      if (pulse1) req1_valid = (k == 1);
      #1;
      chk("exec_ready0", req0_ready, 0);
      chk("exec_ready1", req1_ready, 0);
      chk("exec_busy", busy, 1);
      chk("exec_resp_valid", resp_valid, 0);
      @(posedge clk);
      #1;
    end
    if (pulse1) req1_valid = 1'b0;
    chk("resp_valid_rise", resp_valid, 1);
    chk("resp_c", resp_c, exp_c);
    chk("resp_id", resp_id, g);
    got_c  = resp_c;
    got_id = resp_id;
    for (int unsigned j = 0; j < bp; j++) begin
      @(posedge clk);
      #1;
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_c", resp_c, exp_c);
      chk("bp_resp_id", resp_id, g);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_resp_valid", resp_valid, 0);
    chk("hs_busy", busy, 0);
  endtask

  initial begin
    logic [31:0] c;
    logic        id;
    int unsigned m;

    do_reset();

    // single add from requester 0
    txn(1, 0, 32'h3F980000, 32'h3F100000, 0, 32'h0, 32'h0, 0, 0, 0, c, id);
    chk("t1_value", c, 32'h3FE00000);
    chk("t1_id", id, 0);

    // single subtract from requester 1
    txn(0, 1, 32'h0, 32'h0, 0, 32'h3F980000, 32'h3F100000, 1, 0, 0, c, id);
    chk("t2_value", c, 32'h3F200000);
    chk("t2_id", id, 1);

    // continuous contention from reset alternates 0,1,0,1
    do_reset();
    for (int unsigned n = 0; n < 4; n++) begin
      txn(1, 1, rnd_fp(), rnd_fp(), 1'($urandom_range(1, 0)),
          rnd_fp(), rnd_fp(), 1'($urandom_range(1, 0)), 0, 0, c, id);
      chk("t3_order", id, n % 2);
    end

    // backpressure with a pending request, then the pending one is served
    txn(1, 1, rnd_fp(), rnd_fp(), 0, rnd_fp(), rnd_fp(), 1, 5, 0, c, id);
    txn(1, 1, rnd_fp(), rnd_fp(), 1, rnd_fp(), rnd_fp(), 0, 0, 0, c, id);

    // infinity passes through the adder
    txn(1, 0, 32'h7F800000, 32'h3F800000, 0, 32'h0, 32'h0, 0, 0, 0, c, id);
    chk("inf_value", c, 32'h7F800000);

    // randomized traffic
    for (int unsigned n = 0; n < 40; n++) begin
      m = $urandom_range(3, 1);
      txn(m[0], m[1], rnd_fp(), rnd_fp(), 1'($urandom_range(1, 0)),
          rnd_fp(), rnd_fp(), 1'($urandom_range(1, 0)), $urandom_range(3, 0), 0, c, id);
    end

    // reset in the middle of EXEC
    req0_a = rnd_fp(); req0_b = rnd_fp(); req0_sub = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("t5_ready0", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    #1;
    chk("t5_busy_exec", busy, 1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("t5_async_resp_valid", resp_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_resp_c", resp_c, 0);
    chk("t5_async_ready0", req0_ready, 0);
    chk("t5_async_ready1", req1_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    last = 1'b1;
    for (int unsigned n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      chk("t5_no_stale", resp_valid, 0);
      chk("t5_idle_busy", busy, 0);
    end
    txn(1, 1, rnd_fp(), rnd_fp(), 0, rnd_fp(), rnd_fp(), 0, 0, 0, c, id);
    chk("t5_grant_after_reset", id, 0);

    // withdrawn request while busy, then idle
    txn(1, 0, rnd_fp(), rnd_fp(), 1, 32'h0, 32'h0, 0, 1, 1, c, id);
    for (int unsigned n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_resp_valid", resp_valid, 0);
      chk("t6_idle_ready1", req1_ready, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpa_arbiter.md
Name: fpa_arbiter

Overview:
- Shares one single-precision combinational adder (`fpa`) between two requesters.
- Uses round-robin arbitration and a valid/ready handshake on requests and on the response.
- Latches the operands and gives the adder a programmable multicycle settle window. It registers the result and holds it until the consumer accepts it.
- Supports subtraction by flipping the sign bit of operand b before the adder.
- Sits between the ALU issue logic and the shared `fpa` datapath.

Parameters:
- LAT, 2: cycles the combinational `fpa` is given to settle (multicycle path); legal range 1..15.
- W, 32: operand and result width (IEEE-754 single).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  W  requester 0 operand a
- req0_b  input  W  requester 0 operand b
- req0_sub  input  1  requester 0: 1 = a-b, 0 = a+b
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_c  output  W  registered result
- resp_id  output  1  requester that owns resp_c
- busy  output  1  state != IDLE

Behaviour:
- **Reset (async, immediate):**
  - state=IDLE, ptr=0, cnt=0, op_a=op_b=0.
  - resp_valid=0, resp_c=0, resp_id=0, busy=0.
  - req0_ready=req1_ready=0 while rst is high.
- **States:** IDLE -> EXEC -> RESP -> IDLE.
- **Grant in IDLE (combinational from the valids and ptr):**
  - Only reqN_valid high -> grant N.
  - Both high -> grant ptr.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. At most one ready is high per cycle.
  - Ready is never high outside IDLE.
- **Accept edge (valid && ready):**
  - op_a <= a.
  - op_b <= sub ? {~b[W-1], b[W-2:0]} : b.
  - id <= N; ptr <= ~N; cnt <= LAT-1; state <= EXEC.
- **EXEC:**
  - `fpa` sees op_a and op_b directly from registers.
  - cnt decrements each cycle.
  - On the edge where cnt==0: resp_c <= fpa result, resp_id <= id, resp_valid <= 1, state <= RESP.
  - resp_valid therefore rises LAT edges after the accept edge.
- **RESP:**
  - resp_c and resp_id are held stable while resp_valid=1 && resp_ready=0.
  - On resp_valid && resp_ready: resp_valid <= 0, state <= IDLE.
  - The next accept happens no earlier than the edge after the response handshake. There is no same-edge re-accept.
- **Requester rules:**
  - A requester may drop valid before it sees ready; no operation is accepted.
  - A requester may change its operands while not granted.
  - Inputs are only sampled on the accept edge.
- **ptr** updates only on accept; starvation-free alternation under continuous contention.
- **Special operands** (zero, denormal, inf, NaN) are passed unchanged to `fpa`. The result is whatever `fpa` produces; no flag logic.
- **Reset mid-operation:** the in-flight operation is discarded, no response is emitted, and ptr returns to 0.
- **LAT=1:** EXEC lasts exactly one cycle (cnt loaded with 0).
- **cnt width:** 4 bits.

Decomposition:
- **Shared package `fpa_pkg`:**
  - state enum (IDLE, EXEC, RESP).
  - FP_W=32, FP_SIGN=31.
  - exponent field [30:23] and mantissa field [22:0] range constants.
- **Sub-module:** the existing `fpa` adder, instantiated once with ports (op_a, op_b, sum). No other sub-module.

Test Plan:
1. **Single add:** req0 a=0x3F980000 (1.1875), b=0x3F100000 (0.5625), sub=0, LAT=2 -> accept at edge k; resp_valid at edge k+2 with resp_c=0x3FE00000 (1.75), resp_id=0; busy high for the whole operation.
2. **Single subtract:** req1 with the same a and b, sub=1 -> resp_c=0x3F200000 (0.625), resp_id=1; req0_ready stays 0 throughout.
3. **Contention:**
   - Both valid continuously from reset, resp_ready=1 -> grant order 0,1,0,1 over four operations.
   - Each next accept comes one edge after the previous response handshake.
4. **Backpressure:**
   - Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_c and resp_id stay unchanged.
   - Both req*_ready stay 0.
   - The pending request is accepted only on the edge after resp_ready rises.
5. **Reset mid-EXEC:**
   - Assert rst between clock edges during EXEC -> resp_valid=0, busy=0 and resp_c=0 immediately, without waiting for a clock edge.
   - After release, no stale response appears.
   - A following simultaneous request is granted to req0.
6. **Withdrawn request:** req1_valid pulses for one cycle while busy -> it is never accepted; after the current response completes with no valid asserted, the block idles with busy=0.
